counter_load_sched: RTL and testbench
=====================================

COUNTER_LOAD_SCHED -- requirements
Module: counter_load_sched

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, cycles spent in HOLD after each load; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset is asynchronous and active-low.
REQ-004 req_i  input  4  per-requester load request, bit k = requester k.
REQ-005 load_vals_i  input  16  requester k load value in bits [4k+3:4k].
REQ-006 gnt_o  output  4  one-hot grant pulse, high for exactly the LOAD cycle.
REQ-007 load_o  output  1  load strobe to the shared 4-bit loadable counter.
REQ-008 load_val_o  output  4  value to load, valid when load_o=1.
REQ-009 owner_o  output  2  index of the most recently granted requester.
REQ-010 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-011 FSM states SHALL be IDLE, LOAD, HOLD; every output is registered.
REQ-012 IDLE, req_i==0: stay IDLE; load_o=0, gnt_o=0.
REQ-013 IDLE, req_i!=0: select winner round-robin, capture winner index and its load_vals_i nibble, go to LOAD at the next edge.
REQ-014 Round-robin priority starts at (last_owner+1) mod 4 and ascends with wrap (3->0); the winner becomes last_owner.
REQ-015 LOAD lasts exactly 1 cycle: load_o=1, load_val_o=captured value, gnt_o=one-hot(winner), owner_o=winner; then go to HOLD.
REQ-016 Latency: request sampled at edge N yields load_o=1 in the cycle following edge N+1; value loaded is the one present at edge N.
REQ-017 HOLD lasts exactly HOLD_CYCLES cycles (4-bit down-counter loaded with HOLD_CYCLES-1 on LOAD->HOLD), then IDLE; requests are ignored in LOAD and HOLD.
REQ-018 A request dropped after capture still completes its LOAD; requesters hold req_i until gnt_o and deassert it the cycle after gnt_o, otherwise they are re-arbitrated.
REQ-019 A requester holding req_i continuously while others request is granted at most once per 4 consecutive grants (no starvation).
REQ-020 Minimum spacing between consecutive load_o pulses SHALL be HOLD_CYCLES+2 cycles (LOAD + HOLD + IDLE arbitration).
REQ-021 load_val_o SHALL hold its last value outside LOAD; gnt_o SHALL be 0 outside LOAD.

Reset
REQ-022 reset_n=0 SHALL immediately force state IDLE, load_o=0, gnt_o=0, load_val_o=0, owner_o=0, busy_o=0, hold counter 0, last_owner=3 (requester 0 highest priority after reset).
REQ-023 Reset asserted during LOAD or HOLD aborts the operation; load_o deasserts asynchronously; no grant is issued after release until a fresh IDLE arbitration.
REQ-024 Outputs SHALL leave reset values only on the first rising edge after reset_n rises.

Structure
REQ-025 Package counter_sched_pkg SHALL hold NUM_REQ=4, CNT_W=4, and the state enum type (IDLE, LOAD, HOLD).
REQ-026 Round-robin selection SHALL be a separate combinational sub-module rr_arbiter (inputs req, last_owner; outputs one-hot grant, index, valid).
REQ-027 counter_load_sched instantiates rr_arbiter and the FSM; it does not contain the counter itself.

Verification
REQ-028 Reset then req_i=4'b0101, vals 0x3/-/0x9/- -> grant 0: gnt_o=0001, load_val_o=3; next grant 2: gnt_o=0100, load_val_o=9, spacing 6 cycles (HOLD_CYCLES=4).
REQ-029 req_i=4'b1111 held continuously -> grant order 0,1,2,3,0 with owner_o tracking each.
REQ-030 req_i pulsed one cycle (k=3, value 0xF) in IDLE -> LOAD still issued with load_val_o=F, gnt_o=1000.
REQ-031 Request arriving during HOLD -> no gnt_o until HOLD expires; busy_o high throughout LOAD+HOLD.
REQ-032 reset_n low mid-HOLD -> load_o, gnt_o, busy_o, owner_o go 0 without a clock edge; after release, req_i=1000 is granted to requester 3.
REQ-033 HOLD_CYCLES=1 with req_i=0001 held -> load_o pulses every 3 cycles with value load_vals_i[3:0].

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared sizes and FSM state encoding for the counter load scheduler.
package counter_sched_pkg;
  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 4;
  localparam int IDX_W   = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/counter_load_sched_rr_arbiter.sv
// Combinational round-robin pick: search starts one past last_owner_i and wraps.
module rr_arbiter
  import counter_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_owner_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               vld_o
);

  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (req_i[IDX_W'(last_owner_i + IDX_W'(i))]) begin
        idx_o = IDX_W'(last_owner_i + IDX_W'(i));
        vld_o = 1'b1;
      end
    end
    gnt_o = vld_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/counter_load_sched.sv
// Grants one requester at a time the right to load a shared counter, then holds off for HOLD_CYCLES.
// Outputs are registered from the FSM state, so load_o appears one cycle after the LOAD state is entered.
module counter_load_sched
  import counter_sched_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CNT_W-1:0] load_vals_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic                     load_o,
  output logic [CNT_W-1:0]         load_val_o,
  output logic [IDX_W-1:0]         owner_o,
  output logic                     busy_o
);

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]     last_owner_q, last_owner_d;
  logic [IDX_W-1:0]     win_idx_q, win_idx_d;
  logic [NUM_REQ-1:0]   win_gnt_q, win_gnt_d;
  logic [CNT_W-1:0]     win_val_q, win_val_d;

  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 load_q, load_d;
  logic [CNT_W-1:0]     load_val_q, load_val_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 busy_q, busy_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_vld;

  rr_arbiter u_rr_arbiter (
    .req_i        (req_i),
    .last_owner_i (last_owner_q),
    .gnt_o        (arb_gnt),
    .idx_o        (arb_idx),
    .vld_o        (arb_vld)
  );

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;
    win_idx_d    = win_idx_q;
    win_gnt_d    = win_gnt_q;
    win_val_d    = win_val_q;
    unique case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d      = LOAD;
          win_idx_d    = arb_idx;
          win_gnt_d    = arb_gnt;
          win_val_d    = load_vals_i[int'(arb_idx)*CNT_W +: CNT_W];
          last_owner_d = arb_idx;
        end
      end
      LOAD: begin
        state_d    = HOLD;
        hold_cnt_d = HOLD_INIT;
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage mirrors the current state one cycle later; value and owner persist outside LOAD.
  always_comb begin
    load_d     = (state_q == LOAD);
    gnt_d      = (state_q == LOAD) ? win_gnt_q : '0;
    load_val_d = (state_q == LOAD) ? win_val_q : load_val_q;
    owner_d    = (state_q == LOAD) ? win_idx_q : owner_q;
    busy_d     = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      win_idx_q    <= '0;
      win_gnt_q    <= '0;
      win_val_q    <= '0;
      gnt_q        <= '0;
      load_q       <= 1'b0;
      load_val_q   <= '0;
      owner_q      <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
      win_idx_q    <= win_idx_d;
      win_gnt_q    <= win_gnt_d;
      win_val_q    <= win_val_d;
      gnt_q        <= gnt_d;
      load_q       <= load_d;
      load_val_q   <= load_val_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt_o      = gnt_q;
  assign load_o     = load_q;
  assign load_val_o = load_val_q;
  assign owner_o    = owner_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_counter_load_sched.sv
// Directed bench for counter_load_sched: cycle table plus hand-written multi-cycle sequences.
module tb_counter_load_sched;
  import counter_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req, req1;
  logic [15:0] vals, vals1;
  logic [3:0]  gnt, gnt1;
  logic        load, load1;
  logic [3:0]  lval, lval1;
  logic [1:0]  owner, owner1;
  logic        busy, busy1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_load_sched #(.HOLD_CYCLES(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_i(req), .load_vals_i(vals),
    .gnt_o(gnt), .load_o(load), .load_val_o(lval), .owner_o(owner), .busy_o(busy)
  );

  counter_load_sched #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .req_i(req1), .load_vals_i(vals1),
    .gnt_o(gnt1), .load_o(load1), .load_val_o(lval1), .owner_o(owner1), .busy_o(busy1)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       load;
    logic [3:0] val;
    logic [1:0] owner;
    logic       busy;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0; req1 = '0; vals = '0; vals1 = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, prev, nl;
    logic [1:0] exp_order [5];

    // Trace for two competing requesters, sampled after each rising edge.
    tbl[0] = '{4'b0101, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0};
    tbl[1] = '{4'b0101, 4'b0001, 1'b1, 4'h3, 2'd0, 1'b1};
    tbl[2] = '{4'b0100, 4'b0000, 1'b0, 4'h3, 2'd0, 1'b1};
    tbl[3] = '{4'b0100, 4'b0000, 1'b0, 4'h3, 2'd0, 1'b1};
    tbl[4] = '{4'b0100, 4'b0000, 1'b0, 4'h3, 2'd0, 1'b1};
    tbl[5] = '{4'b0100, 4'b0000, 1'b0, 4'h3, 2'd0, 1'b1};
    tbl[6] = '{4'b0100, 4'b0000, 1'b0, 4'h3, 2'd0, 1'b0};
    tbl[7] = '{4'b0100, 4'b0100, 1'b1, 4'h9, 2'd2, 1'b1};
    tbl[8] = '{4'b0000, 4'b0000, 1'b0, 4'h9, 2'd2, 1'b1};
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    reset_n = 1'b0;
    req = '0; req1 = '0; vals = '0; vals1 = '0;
    #3;
    chk("rst_gnt",   32'(gnt),   0);
    chk("rst_load",  32'(load),  0);
    chk("rst_val",   32'(lval),  0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy",  32'(busy),  0);
    tick();
    reset_n = 1'b1;

    vals = 16'h0903;
    for (int i = 0; i < 9; i++) begin
      req = tbl[i].req;
      tick();
      chk($sformatf("tbl%0d_gnt", i),   32'(gnt),   32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_load", i),  32'(load),  32'(tbl[i].load));
      chk($sformatf("tbl%0d_val", i),   32'(lval),  32'(tbl[i].val));
      chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
      chk($sformatf("tbl%0d_busy", i),  32'(busy),  32'(tbl[i].busy));
    end

    // All four requesting continuously: rotation 0,1,2,3,0 at 6-cycle spacing.
    do_reset();
    req = 4'b1111;
    vals = 16'h4321;
    n = 0; prev = 0;
    for (int c = 1; c <= 60 && n < 5; c++) begin
      tick();
      if (gnt != 4'b0000) begin
        chk($sformatf("rr%0d_gnt", n),   32'(gnt),   32'(4'b0001 << exp_order[n]));
        chk($sformatf("rr%0d_owner", n), 32'(owner), 32'(exp_order[n]));
        chk($sformatf("rr%0d_val", n),   32'(lval),  32'(exp_order[n]) + 1);
        if (n > 0) chk($sformatf("rr%0d_spacing", n), 32'(c - prev), 6);
        prev = c;
        n++;
      end
    end
    chk("rr_grant_count", 32'(n), 5);

    // Single-cycle pulse from requester 3, then a request arriving during HOLD.
    do_reset();
    vals = 16'hF000;
    req = 4'b1000;
    tick();
    req = 4'b0000;
    vals = 16'h0000;
    tick();
    chk("pulse_load",  32'(load),  1);
    chk("pulse_gnt",   32'(gnt),   32'(4'b1000));
    chk("pulse_val",   32'(lval),  32'hF);
    chk("pulse_owner", 32'(owner), 3);
    req = 4'b0001;
    vals = 16'h0005;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("hold%0d_gnt", i),  32'(gnt),  0);
      chk($sformatf("hold%0d_busy", i), 32'(busy), 1);
    end
    tick();
    chk("arb_idle_busy", 32'(busy), 0);
    chk("arb_idle_gnt",  32'(gnt),  0);
    tick();
    chk("after_hold_gnt",   32'(gnt),   32'(4'b0001));
    chk("after_hold_val",   32'(lval),  5);
    chk("after_hold_owner", 32'(owner), 0);

    // Asynchronous reset while load_o is high and the FSM is in HOLD.
    do_reset();
    vals = 16'h0070;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    chk("pre_abort_load",  32'(load),  1);
    chk("pre_abort_owner", 32'(owner), 1);
    reset_n = 1'b0;
    #2;
    chk("abort_load",  32'(load),  0);
    chk("abort_gnt",   32'(gnt),   0);
    chk("abort_busy",  32'(busy),  0);
    chk("abort_owner", 32'(owner), 0);
    chk("abort_val",   32'(lval),  0);
    #1;
    reset_n = 1'b1;
    req = 4'b1000;
    vals = 16'hC000;
    tick();
    chk("post_abort_load0", 32'(load), 0);
    chk("post_abort_gnt0",  32'(gnt),  0);
    req = 4'b0000;
    tick();
    chk("post_abort_gnt",   32'(gnt),   32'(4'b1000));
    chk("post_abort_val",   32'(lval),  32'hC);
    chk("post_abort_owner", 32'(owner), 3);

    // HOLD_CYCLES=1 instance with a held request: a load every 3 cycles.
    do_reset();
    req1 = 4'b0001;
    vals1 = 16'h000A;
    nl = 0; prev = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (load1) begin
        chk($sformatf("h1_load%0d_val", nl), 32'(lval1), 32'hA);
        if (nl == 0) chk("h1_first_load_cycle", 32'(c), 2);
        else chk($sformatf("h1_load%0d_spacing", nl), 32'(c - prev), 3);
        prev = c;
        nl++;
      end
    end
    chk("h1_load_count", 32'(nl), 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
